// File: rtl/scirc_pkg.sv
// scirc_pkg: shared defaults and packer FSM state type for the scirc y_out packer.
package scirc_pkg;
  localparam int SCIRC_WORD_W = 8;
  localparam int SCIRC_FIFO_DEPTH = 4;
  typedef enum logic {IDLE, FILL} pack_state_e;
endpackage

// File: rtl/scirc_fifo.sv
// scirc_fifo: generic synchronous FIFO with explicit occupancy counter; head reads 0 when empty.
module scirc_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign data_o = empty_o ? '0 : mem_q[rd_q];
  // A pop frees the slot a same-edge push into a full FIFO needs.
  always_comb begin
    do_pop = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = data_i;
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/scirc_y_packer.sv
// scirc_y_packer: packs the scirc528 y_out bit stream LSB-first into words and queues them for a host.
// Optional SCIRC_Y_PACKER_PARITY_EN stores each word's even parity and exposes it on parity_o.
module scirc_y_packer
  import scirc_pkg::*;
#(
  parameter int WORD_W = SCIRC_WORD_W,
  parameter int DEPTH = SCIRC_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     y_i,
  input  logic                     y_valid_i,
  output logic [WORD_W-1:0]        word_o,
  output logic                     word_valid_o,
  input  logic                     word_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
`ifdef SCIRC_Y_PACKER_PARITY_EN
  output logic                     parity_o,
`endif
  output logic                     overflow_o
);
  localparam int CW = $clog2(WORD_W);
`ifdef SCIRC_Y_PACKER_PARITY_EN
  localparam int FW = WORD_W + 1;
`else
  localparam int FW = WORD_W;
`endif
  pack_state_e state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic overflow_q, overflow_d;
  logic last, full, empty, pop;
  logic [FW-1:0] push_data, head;
  // The completing bit is merged combinationally so the whole word pushes on its final edge.
  always_comb begin
    word_d = shift_q;
    word_d[cnt_q] = y_i;
    last = y_valid_i && cnt_q == CW'(WORD_W - 1);
    pop = word_valid_o && word_ready_i;
    shift_d = !y_valid_i ? shift_q : last ? '0 : word_d;
    cnt_d = !y_valid_i ? cnt_q : last ? '0 : cnt_q + CW'(1);
    state_d = !y_valid_i ? state_q : last ? IDLE : FILL;
    overflow_d = overflow_q | (last && full && !pop);
  end
`ifdef SCIRC_Y_PACKER_PARITY_EN
  assign push_data = {^word_d, word_d};
  assign parity_o = head[WORD_W];
`else
  assign push_data = word_d;
`endif
  assign word_o = head[WORD_W-1:0];
  assign word_valid_o = !empty;
  assign overflow_o = overflow_q;
  scirc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (last),
    .pop_i   (pop),
    .data_i  (push_data),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q <= cnt_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: doc/scirc_y_packer.md
Name: scirc_y_packer

Overview:
- Downstream consumer of the scirc528 sequential circuit.
- Samples its serial y_out bit stream and packs bits LSB-first into WORD_W-bit words.
- Buffers completed words in a small synchronous FIFO and presents them on a valid/ready interface for a host or logger.
- Lets the team capture and check long y_out traces as words instead of single waveform bits.

Parameters:
- WORD_W, 8, bits per packed word (≥2).
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- y_i  in  1  serial bit from scirc528 y_out
- y_valid_i  in  1  sample enable; y_i is captured on edges where it is 1 (tied 1 in system use)
- word_o  out  WORD_W  head-of-FIFO word; 0 when FIFO empty
- word_valid_o  out  1  FIFO non-empty
- word_ready_i  in  1  consumer accepts head word this edge
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
- overflow_o  out  1  sticky: a completed word was dropped

Behaviour:
- Reset:
  - Only rst_i=1 at a rising edge resets the block.
  - Clears the shift register, bit counter, FIFO pointers and overflow_o.
  - FSM goes to IDLE.
  - All outputs are 0 the cycle after.
  - Reset mid-word discards the partial bits.
  - Reset has priority over every other event.
- FSM states:
  - IDLE: no bits held. y_valid_i=1 → shift y_i into bit 0, bit_cnt=1, go to FILL.
  - FILL: y_valid_i=1 → y_i goes to bit position bit_cnt, bit_cnt++.
  - When the captured bit is bit WORD_W-1:
    - the full word (including that bit) is pushed to the FIFO on that same edge;
    - bit_cnt returns to 0 and the FSM goes to IDLE.
  - FILL with y_valid_i=0 → hold state, no change.
  - Exception, WORD_W=1 path: not supported, and WORD_W<2 is illegal.
- Bit order: the first sampled bit is word bit 0. The last sampled bit is bit WORD_W-1.
- Latency: the word appears on word_o, with word_valid_o=1, the cycle after the edge that captured its final bit (push-to-visible = 1 cycle).
- Pop: on an edge with word_valid_o && word_ready_i. word_o must show the next entry, or 0 if empty, the following cycle.
- word_ready_i with FIFO empty: no effect. No underflow, and count_o stays 0.
- Full FIFO (count_o==DEPTH) with push and no pop:
  - the word is dropped and FIFO contents are unchanged;
  - overflow_o goes to 1 and stays 1 until reset.
- Full FIFO with push and pop on the same edge: both take effect, count_o stays DEPTH, no overflow.
- Simultaneous push and pop at any non-full occupancy: count_o unchanged, order preserved.
- Pointers wrap modulo DEPTH. count_o is an explicit counter, not a pointer difference.
- word_o and word_valid_o are stable while word_valid_o=1 and word_ready_i=0.

Optional Feature:
- Macro: SCIRC_Y_PACKER_PARITY_EN.
- Defined:
  - each FIFO entry also stores the even-parity bit of its word (XOR of all bits);
  - extra port parity_o (out, 1) carries the head entry's parity alongside word_o;
  - parity_o is 0 when the FIFO is empty.
- Undefined: no parity storage, no parity_o port. Behaviour is otherwise identical.

Decomposition:
- Package scirc_pkg holds:
  - localparam defaults SCIRC_WORD_W=8 and SCIRC_FIFO_DEPTH=4;
  - the packer FSM state typedef (IDLE, FILL).
- One sub-module, scirc_fifo:
  - generic synchronous FIFO parameterised by data width and DEPTH;
  - exposes push/pop/full/empty/count and the head data.
- The packer instantiates it with width WORD_W, or WORD_W+1 when parity is enabled.

Test Plan:
1. Reset then y_valid_i=1, y_i stream 1,0,1,1,0,0,1,0 with word_ready_i=0 → one cycle after the 8th edge: word_o=8'h4D, word_valid_o=1, count_o=1. With parity enabled, parity_o=0.
2. Five words 8'h01..8'h05 with word_ready_i=0 (DEPTH=4) → count_o=4, overflow_o=1 after the 5th word, head stays 8'h01. Then draining 4 pops yields 01,02,03,04 in order and count_o=0, while overflow_o stays 1.
3. FIFO full, and the 8th bit of word 8'hAA lands on the same edge as a pop → no overflow, count_o stays 4, 8'hAA becomes the last entry.
4. y_valid_i toggled 1/0 every cycle while shifting 8'hF0 → the word completes only after 8 valid samples; word_o=8'hF0.
5. rst_i=1 for one edge after 3 bits of a word → all outputs 0. The next 8 valid bits 0xFF (all 1s) produce word_o=8'hFF, with no stale bits.
6. Tie y_i to scirc528_bh y_out, drive x_i as 00,11,01,10 per clock → packed words match a bit-by-bit model of the y_out trace, and word_ready_i=1 throughout keeps count_o ≤1.
